// File: rtl/ula_pkg.sv
// Shared definitions for the logic-unit front end: FSM state codes, operation codes, operand width.
package ula_pkg;

   localparam int LARGURA = 8;

   typedef enum logic [1:0] {
      CARREGA_A  = 2'b00,
      CARREGA_B  = 2'b01,
      ENVIA      = 2'b10,
      ESTADO_INV = 2'b11
   } estado_t;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOT = 2'b11;

endpackage

// File: rtl/carregador_operandos_ula_if.sv
// Operand bus toward the logic unit: A, B and op qualified by valid, accepted by ready.
interface carregador_operandos_ula_if #(
   parameter int LARGURA = 8
) ();
   logic [LARGURA-1:0] A;
   logic [LARGURA-1:0] B;
   logic [1:0]         op;
   logic               valid;
   logic               ready;

   modport master (output A, output B, output op, output valid, input ready);
   modport slave  (input A, input B, input op, input valid, output ready);
endinterface

// File: rtl/detector_borda.sv
// Two-flop synchronizer plus rising-edge detector; one-cycle pulse two edges after the input rises.
// No debounce: each clean rising edge seen after synchronization yields one pulse.
module detector_borda (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);
   logic sync1;
   logic sync2;
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign pulse = sync2 & ~prev;
endmodule

// File: rtl/carregador_operandos_ula.sv
// Loads A then B from switches on confirm, then offers {A,B,op} with valid until ready or cancel.
// Transfer completes on the edge where valid&ready; all outputs registered, results held for display.
module carregador_operandos_ula
   import ula_pkg::*;
#(
   parameter int LARGURA      = ula_pkg::LARGURA,
   parameter int LARGURA_CONT = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LARGURA-1:0]      sw,
   input  logic                    btn_confirma,
   input  logic                    btn_cancela,
   input  logic [1:0]              sel_op,
   carregador_operandos_ula_if.master bus,
   output logic [1:0]              estado,
   output logic [LARGURA_CONT-1:0] cont_ops
);
   logic               pulso_conf;
   logic               pulso_canc;
   estado_t            est;
   logic [LARGURA-1:0] reg_a;
   logic [LARGURA-1:0] reg_b;
   logic [1:0]         reg_op;
   logic               reg_valid;

   detector_borda u_confirma (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_confirma),
      .pulse (pulso_conf)
   );

   detector_borda u_cancela (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_cancela),
      .pulse (pulso_canc)
   );

   // sw is asynchronous but the operator holds it steady across the confirm
   // synchronizer delay, so it is captured directly without its own synchronizer.
   always_ff @(posedge clk) begin
      if (rst) begin
         est       <= CARREGA_A;
         reg_a     <= '0;
         reg_b     <= '0;
         reg_op    <= OP_AND;
         reg_valid <= 1'b0;
         cont_ops  <= '0;
      end else begin
         case (est)
            CARREGA_A: begin
               if (!pulso_canc && pulso_conf) begin
                  reg_a <= sw;
                  est   <= CARREGA_B;
               end
            end
            CARREGA_B: begin
               if (pulso_canc) begin
                  reg_a <= '0;
                  est   <= CARREGA_A;
               end else if (pulso_conf) begin
                  reg_b     <= sw;
                  reg_op    <= sel_op;
                  reg_valid <= 1'b1;
                  est       <= ENVIA;
               end
            end
            ENVIA: begin
               // A transfer in the same cycle as cancel still counts.
               if (reg_valid && bus.ready) begin
                  reg_valid <= 1'b0;
                  cont_ops  <= cont_ops + 1'b1;
                  est       <= CARREGA_A;
               end else if (pulso_canc) begin
                  reg_valid <= 1'b0;
                  est       <= CARREGA_A;
               end
            end
            default: begin
               reg_valid <= 1'b0;
               est       <= CARREGA_A;
            end
         endcase
      end
   end

   assign bus.A     = reg_a;
   assign bus.B     = reg_b;
   assign bus.op    = reg_op;
   assign bus.valid = reg_valid;
   assign estado    = est;
endmodule
